// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART frame sequencer: default sizes, FSM encoding, ALU opcodes.
package alu_uart_pkg;

    localparam int unsigned DEF_NBIT    = 8;
    localparam int unsigned DEF_OPBIT   = 6;
    localparam int unsigned DEF_TIMEOUT = 1_000_000;
    localparam int unsigned DEF_TO_BIT  = 20;
    localparam int unsigned ERR_BIT     = 8;
    localparam int unsigned ST_BIT      = 3;

    // Sequencer states
    localparam logic [ST_BIT-1:0] ST_GET_A  = 3'd0;
    localparam logic [ST_BIT-1:0] ST_GET_B  = 3'd1;
    localparam logic [ST_BIT-1:0] ST_GET_OP = 3'd2;
    localparam logic [ST_BIT-1:0] ST_EXEC   = 3'd3;
    localparam logic [ST_BIT-1:0] ST_SEND   = 3'd4;

    // ALU opcodes (6-bit field of the third frame byte)
    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;

endpackage

// File: rtl/alu_uart_sequencer_if.sv
// FIFO handshakes and ALU operand/result bundle seen by the frame sequencer.
interface alu_uart_sequencer_if
    import alu_uart_pkg::*;
#(
    parameter int unsigned NBIT  = DEF_NBIT,
    parameter int unsigned OPBIT = DEF_OPBIT
);
    logic               rx_empty;
    logic [NBIT-1:0]    r_data;
    logic               rd_uart;
    logic               tx_full;
    logic               wr_uart;
    logic [NBIT-1:0]    w_data;
    logic [NBIT-1:0]    alu_a;
    logic [NBIT-1:0]    alu_b;
    logic [OPBIT-1:0]   alu_op;
    logic [NBIT-1:0]    alu_result;
    logic               busy;
    logic [ERR_BIT-1:0] err_count;

    modport master (
        input  rx_empty, r_data, tx_full, alu_result,
        output rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op, busy, err_count
    );

    modport slave (
        output rx_empty, r_data, tx_full, alu_result,
        input  rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op, busy, err_count
    );
endinterface

// File: rtl/alu_uart_sequencer_frame_timer.sv
// Inter-byte gap timer: pulses expired on the idle cycle that reaches TIMEOUT-1.
module frame_timer #(
    parameter int unsigned TIMEOUT = 1_000_000,
    parameter int unsigned TO_BIT  = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [TO_BIT-1:0] count;

    // Limit hit only counts while still idle; a byte in that cycle wins
    assign expired = enable && (count == TO_BIT'(TIMEOUT - 1));

    // Idle-cycle counter, restarted by clear or by its own expiry
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear || expired) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TO_BIT'(1);
        end
    end
endmodule

// File: rtl/alu_uart_sequencer.sv
// Frame sequencer: pops A, B, opcode from RX FIFO, drives the ALU, pushes the result to TX FIFO.
module alu_uart_sequencer
    import alu_uart_pkg::*;
#(
    parameter int unsigned NBIT    = DEF_NBIT,
    parameter int unsigned OPBIT   = DEF_OPBIT,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned TO_BIT  = DEF_TO_BIT
) (
    input  logic                 CLK,
    input  logic                 RESET,
    alu_uart_sequencer_if.master bus
);
    logic [ST_BIT-1:0]  state;
    logic [ST_BIT-1:0]  state_next;
    logic [NBIT-1:0]    a_q;
    logic [NBIT-1:0]    b_q;
    logic [OPBIT-1:0]   op_q;
    logic [NBIT-1:0]    w_q;
    logic [ERR_BIT-1:0] err_q;
    logic               load_a;
    logic               load_b;
    logic               load_op;
    logic               load_w;
    logic               send;
    logic               timer_en;
    logic               timer_clear;
    logic               expired;

    // Gap timer runs only while waiting mid-frame on an empty RX FIFO
    assign timer_en    = ((state == ST_GET_B) || (state == ST_GET_OP)) && bus.rx_empty;
    assign timer_clear = ~timer_en;

    frame_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_BIT  (TO_BIT)
    ) u_timer (
        .clk     (CLK),
        .rst     (RESET),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (expired)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_GET_A;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and load/handshake decode
    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_op    = 1'b0;
        load_w     = 1'b0;
        send       = 1'b0;
        case (state)
            ST_GET_A: begin
                if (!bus.rx_empty) begin
                    load_a     = 1'b1;
                    state_next = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (!bus.rx_empty) begin
                    load_b     = 1'b1;
                    state_next = ST_GET_OP;
                end else if (expired) begin
                    state_next = ST_GET_A;
                end
            end
            ST_GET_OP: begin
                if (!bus.rx_empty) begin
                    load_op    = 1'b1;
                    state_next = ST_EXEC;
                end else if (expired) begin
                    state_next = ST_GET_A;
                end
            end
            ST_EXEC: begin
                load_w     = 1'b1;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (!bus.tx_full) begin
                    send       = 1'b1;
                    state_next = ST_GET_A;
                end
            end
            default: state_next = ST_GET_A;
        endcase
    end

    // Operand, result and dropped-frame registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            w_q   <= '0;
            err_q <= '0;
        end else begin
            if (load_a)  a_q  <= bus.r_data;
            if (load_b)  b_q  <= bus.r_data;
            if (load_op) op_q <= bus.r_data[OPBIT-1:0];
            if (load_w)  w_q  <= bus.alu_result;
            if (expired && (err_q != '1)) err_q <= err_q + ERR_BIT'(1);
        end
    end

    // FIFO strobes are suppressed during reset so queue contents survive it
    assign bus.rd_uart   = (load_a | load_b | load_op) & ~RESET;
    assign bus.wr_uart   = send & ~RESET;
    assign bus.w_data    = w_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_op    = op_q;
    assign bus.busy      = (state != ST_GET_A);
    assign bus.err_count = err_q;
endmodule

// File: doc/alu_uart_sequencer.md
# alu_uart_sequencer

Frame sequencer between the UART FIFOs and the ALU datapath. It pops three bytes from the RX FIFO in order: operand A, operand B, opcode. It presents them to the ALU as registered operands, captures the ALU result and pushes it into the TX FIFO. Partial frames are discarded by a byte-gap timeout. It replaces the separate RX and TX interface FSMs with a single controller that owns both FIFO handshakes.

## Interface
- NBIT, 8, data/operand width (equals UART word width)
- OPBIT, 6, opcode width; low OPBIT bits of the third byte
- TIMEOUT, 1_000_000, max idle cycles between bytes of one frame
- TO_BIT, 20, timeout counter width; must satisfy 2^TO_BIT > TIMEOUT

- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- rx_empty  in  1  RX FIFO empty
- r_data  in  NBIT  RX FIFO head word, valid whenever rx_empty=0
- rd_uart  out  1  RX FIFO pop, one cycle per byte
- tx_full  in  1  TX FIFO full
- wr_uart  out  1  TX FIFO push, one cycle per result
- w_data  out  NBIT  result word to TX FIFO (registered)
- alu_a  out  NBIT  operand A (registered)
- alu_b  out  NBIT  operand B (registered)
- alu_op  out  OPBIT  opcode (registered)
- alu_result  in  NBIT  combinational ALU output
- busy  out  1  high in any state except GET_A
- err_count  out  8  dropped-frame counter, saturates at 255

## Operation
- States: GET_A, GET_B, GET_OP, EXEC, SEND. Reset state is GET_A.
- GET_A / GET_B / GET_OP, when rx_empty=0:
  - rd_uart=1 in the same cycle (Mealy).
  - r_data is latched into alu_a / alu_b / alu_op (alu_op takes r_data[OPBIT-1:0]).
  - The state advances on that edge. When rx_empty=1 the state holds and rd_uart=0.
- EXEC: one cycle. alu_result is latched into w_data at the end of the cycle, then the FSM goes to SEND.
- SEND, when tx_full=0: wr_uart=1 (Mealy), then go to GET_A. When tx_full=1: hold, wr_uart=0, w_data stable.
- Timeout:
  - The counter clears on every accepted byte and on entry to GET_A.
  - It increments each cycle in GET_B or GET_OP while rx_empty=1.
  - When the counter reaches TIMEOUT-1 with rx_empty=1: go to GET_A and increment err_count (saturating). alu_a/alu_b keep their stale values.
- A byte arriving in the cycle the counter hits its limit is accepted; the timeout is not taken.
- No timeout applies in GET_A, EXEC or SEND; a full TX FIFO stalls indefinitely.
- Opcode bits above OPBIT are ignored; any opcode value is forwarded unchanged, with no legality check.
- rd_uart and wr_uart are never high in the same cycle.

## Timing
- Reset values: rd_uart=0, wr_uart=0, w_data=0, alu_a=0, alu_b=0, alu_op=0, busy=0, err_count=0, timeout counter=0.
- Throughput: 5 cycles per frame minimum, with back-to-back bytes available and TX not full.
- Latency, with the opcode pop in cycle n:
  - alu_op valid in cycle n+1 (EXEC).
  - wr_uart=1 in cycle n+2 at the earliest, with w_data already valid.
- The ALU must settle within one cycle of the operands being registered.
- Reset mid-frame: on the next edge return to GET_A. The partial frame is discarded without incrementing err_count. FIFO contents are not touched.

## Structure
- Shared package (alu_uart_pkg):
  - State encoding enum/localparams (3-bit).
  - Default NBIT/OPBIT/TIMEOUT.
  - Opcode constants (ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, XOR 6'h26, NOR 6'h27, SRA 6'h03, SRL 6'h02) for the bench.
- One sub-module, frame_timer:
  - Inputs: clear, enable.
  - Output: expired (one-cycle pulse).
  - Parameterized by TIMEOUT and TO_BIT.

## Test plan
- Bytes 0x05, 0x03, 0x20 preloaded, TX not full, ALU model ADD:
  - rd_uart high 3 consecutive cycles.
  - wr_uart pulse 2 cycles after the last pop, with w_data=0x08.
  - busy back to 0 afterward.
- Bytes 0x0F, 0x3C, 0xE4 (opcode field 0x24 AND) -> alu_op=0x24, w_data=0x0C. Upper opcode bits are ignored.
- TIMEOUT=16, send only 0x11 then idle:
  - Return to GET_A after 16 idle cycles, err_count=1, no wr_uart.
  - A following frame 0x01, 0x01, 0x20 yields 0x02.
- TIMEOUT=16, drive the second byte in the exact cycle the counter reaches 15 -> byte accepted, err_count stays 0.
- Frame 0x80, 0x01, 0x22 (SUB) with tx_full=1 for 10 cycles:
  - FSM holds in SEND with no wr_uart and w_data=0x7F stable.
  - One wr_uart after tx_full drops.
  - No RX pops during the stall.
- RESET asserted one cycle after operand B is popped:
  - All outputs return to reset values, err_count=0.
  - The next three bytes are treated as a new frame.
